alu_decode_stage: RTL

- Registered RISC-V RV32I/M ALU-control decode stage with valid/ready handshake and 2-entry skid buffering.
- Decodes the full R-type and I-ALU opcode space, plus load/store/branch/jump/upper-immediate, into a 5-bit ALU control code.
- Flags illegal encodings, supports pipeline flush, and keeps decode statistics counters.
- Sits between instruction fetch and the execute-stage ALU.

---
 rtl/alu_decode_stage.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//
// Purpose:
//   Registered RV32I/M ALU-control decode stage. It sits between
//   instruction fetch and the execute-stage ALU. Each accepted
//   instruction word is decoded combinationally into a 5-bit ALU
//   control code, a register-write flag and an illegal flag, then
//   captured into the stage registers. A two-entry skid buffer (main
//   register M plus skid register S) lets in_ready be a plain register
//   output with no combinational path from out_ready. Two statistics
//   counters track legal and illegal instructions handed downstream.
//
// Parameters:
//   EN_M   1 = decode the M extension (funct7 0000001 on OP);
//          0 = those encodings are flagged illegal.
//   CNT_W  width of the statistics counters.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush        discard every buffered instruction
//   in_valid     upstream instruction present
//   in_ready     stage can accept (registered, equals ~S.valid)
//   in_instr     raw 32-bit instruction word
//   out_valid    decoded result present in M
//   out_ready    downstream accepts
//   alu_control  5-bit ALU operation code
//   rd/rs1/rs2   register fields instr[11:7], [19:15], [24:20]
//   reg_write    instruction writes rd
//   illegal      unsupported encoding
//   decoded_cnt  legal instructions handed off, wraps
//   illegal_cnt  illegal instructions handed off, saturates at all-ones
// ---------------------------------------------------------------------------
module alu_decode_stage #(
    parameter int EN_M  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       alu_control,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] decoded_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b01010;
    localparam logic [4:0] OP_SRL  = 5'b01011;
    localparam logic [4:0] OP_SRA  = 5'b01100;
    localparam logic [4:0] OP_SLT  = 5'b01101;
    localparam logic [4:0] OP_SLTU = 5'b01110;

    // One decoded instruction as held in either buffer register
    typedef struct packed {
        logic [4:0] aluCtrl;
        logic [4:0] rdAddr;
        logic [4:0] rs1Addr;
        logic [4:0] rs2Addr;
        logic       regWrite;
        logic       illegal;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] decAlu;
    logic       decRegWrite;
    logic       decIllegal;
    entry_t     decEntry;

    entry_t     mData_q, mData_d;
    entry_t     sData_q, sData_d;
    logic       mValid_q, mValid_d;
    logic       sValid_q, sValid_d;
    logic [CNT_W-1:0] decodedCnt_q, decodedCnt_d;
    logic [CNT_W-1:0] illegalCnt_q, illegalCnt_d;

    logic accept;
    logic outFire;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // The funct3 map shared by OP (funct7 0000000) and OP-IMM
    function automatic logic [4:0] baseOp(input logic [2:0] f3);
        logic [4:0] code;
        case (f3)
            3'b000:  code = OP_ADD;
            3'b001:  code = OP_SLL;
            3'b010:  code = OP_SLT;
            3'b011:  code = OP_SLTU;
            3'b100:  code = OP_XOR;
            3'b101:  code = OP_SRL;
            3'b110:  code = OP_OR;
            default: code = OP_AND;
        endcase
        return code;
    endfunction

    // Combinational decode of the offered word. Any illegal result is
    // forced to ADD with no register write so downstream never acts on it.
    always_comb begin
        decAlu      = OP_ADD;
        decRegWrite = 1'b0;
        decIllegal  = 1'b0;
        case (opcode)
            7'b0110011: begin
                decRegWrite = 1'b1;
                if (funct7 == 7'b0000000) begin
                    decAlu = baseOp(funct3);
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      decAlu = OP_SUB;
                    else if (funct3 == 3'b101) decAlu = OP_SRA;
                    else                       decIllegal = 1'b1;
                end else if (funct7 == 7'b0000001 && EN_M != 0) begin
                    // MUL..REMU occupy 10000..10111 in funct3 order
                    decAlu = {2'b10, funct3};
                end else begin
                    decIllegal = 1'b1;
                end
            end
            7'b0010011: begin
                decRegWrite = 1'b1;
                decAlu      = baseOp(funct3);
                // Only the shift forms use instr[31:25] as funct7
                if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
                    decIllegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000)      decAlu = OP_SRA;
                    else if (funct7 != 7'b0000000) decIllegal = 1'b1;
                end
            end
            7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: begin
                decRegWrite = 1'b1;
            end
            7'b0100011: begin
                decRegWrite = 1'b0;
            end
            7'b1100011: begin
                decAlu = OP_SUB;
            end
            default: begin
                decIllegal = 1'b1;
            end
        endcase
        if (decIllegal) begin
            decAlu      = OP_ADD;
            decRegWrite = 1'b0;
        end
    end

    assign decEntry = '{aluCtrl:  decAlu,
                        rdAddr:   in_instr[11:7],
                        rs1Addr:  in_instr[19:15],
                        rs2Addr:  in_instr[24:20],
                        regWrite: decRegWrite,
                        illegal:  decIllegal};

    // Flush wins over a same-cycle offer; in_ready is purely registered
    assign in_ready = ~sValid_q;
    assign accept   = in_valid & ~sValid_q & ~flush;
    assign outFire  = mValid_q & out_ready;

    // Skid-buffer next state. When M can move (empty or draining) it
    // refills from S first to preserve order; S is only ever filled while
    // M is stalled, and in_ready is low while S holds an entry, so an
    // accept and an S->M transfer never coincide.
    always_comb begin
        mValid_d = mValid_q;
        sValid_d = sValid_q;
        mData_d  = mData_q;
        sData_d  = sData_q;
        if (flush) begin
            mValid_d = 1'b0;
            sValid_d = 1'b0;
        end else if (!mValid_q || out_ready) begin
            if (sValid_q) begin
                mValid_d = 1'b1;
                mData_d  = sData_q;
                sValid_d = 1'b0;
            end else if (accept) begin
                mValid_d = 1'b1;
                mData_d  = decEntry;
            end else begin
                mValid_d = 1'b0;
            end
        end else if (accept) begin
            sValid_d = 1'b1;
            sData_d  = decEntry;
        end
    end

    // Statistics advance only on a downstream handshake, flush or not
    always_comb begin
        decodedCnt_d = decodedCnt_q;
        illegalCnt_d = illegalCnt_q;
        if (outFire) begin
            if (mData_q.illegal) begin
                if (illegalCnt_q != {CNT_W{1'b1}}) illegalCnt_d = illegalCnt_q + 1'b1;
            end else begin
                decodedCnt_d = decodedCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mValid_q     <= 1'b0;
            sValid_q     <= 1'b0;
            mData_q      <= '0;
            sData_q      <= '0;
            decodedCnt_q <= '0;
            illegalCnt_q <= '0;
        end else begin
            mValid_q     <= mValid_d;
            sValid_q     <= sValid_d;
            mData_q      <= mData_d;
            sData_q      <= sData_d;
            decodedCnt_q <= decodedCnt_d;
            illegalCnt_q <= illegalCnt_d;
        end
    end

    assign out_valid   = mValid_q;
    assign alu_control = mData_q.aluCtrl;
    assign rd          = mData_q.rdAddr;
    assign rs1         = mData_q.rs1Addr;
    assign rs2         = mData_q.rs2Addr;
    assign reg_write   = mData_q.regWrite;
    assign illegal     = mData_q.illegal;
    assign decoded_cnt = decodedCnt_q;
    assign illegal_cnt = illegalCnt_q;

endmodule
